// File: rtl/impact_sram_access_ctrl.sv
// Access sequencer for one 32x32 IMPACT SRAM bank: precharge, word-line pulse, write drive, read sample.
// Latency: accept-to-rsp_valid = P+A+1 cycles; one access per P+A+R+1 cycles.
// Backpressure: req_ready only in IDLE (from state, not req_valid); rsp_valid is a one-cycle pulse with no backpressure.
module impact_sram_access_ctrl #(
  parameter int PRE_CYCLES = 2,
  parameter int ACC_CYCLES = 3,
  parameter int REC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic [31:0] bl_in,
  output logic [4:0]  wl_sel,
  output logic        wl_en,
  output logic        pre_en,
  output logic        wr_en,
  output logic [31:0] bl_drv,
  output logic [31:0] blb_drv,
  output logic        busy
);

  // A zero duration would stall the down-counter, so clamp into the 4-bit range 1..15.
  function automatic int eff_cycles(input int v);
    if (v < 1) return 1;
    if (v > 15) return 15;
    return v;
  endfunction

  localparam logic [3:0] P_EFF = 4'(eff_cycles(PRE_CYCLES));
  localparam logic [3:0] A_EFF = 4'(eff_cycles(ACC_CYCLES));
  localparam logic [3:0] R_EFF = 4'(eff_cycles(REC_CYCLES));

  typedef enum logic [1:0] {IDLE, PRE, ACC, REC} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        rd_capture;

  // Next state, phase counter and all bank-control outputs, decoded from the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    pre_en     = 1'b1;
    wl_en      = 1'b0;
    wr_en      = 1'b0;
    bl_drv     = '0;
    blb_drv    = '0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !rst;
        accept    = req_valid && !rst;
        if (accept) begin
          state_d = PRE;
          cnt_d   = P_EFF;
        end
      end
      PRE: begin
        if (cnt_q == 4'd1) begin
          state_d = ACC;
          cnt_d   = A_EFF;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACC: begin
        pre_en = 1'b0;
        wl_en  = 1'b1;
        wr_en  = we_q;
        if (we_q) begin
          bl_drv  = wdata_q;
          blb_drv = ~wdata_q;
        end
        if (cnt_q == 4'd1) begin
          rd_capture = !we_q;
          state_d    = REC;
          cnt_d      = R_EFF;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REC: begin
        // The counter is loaded with R on entry, so it equals R only in the first REC cycle.
        rsp_valid = (cnt_q == R_EFF);
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State register plus request latch; wl_sel moves only on acceptance so the decoder settles during PRE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wl_sel    <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        wdata_q <= req_wdata;
        wl_sel  <= req_addr;
      end
      if (rd_capture) begin
        rsp_rdata <= bl_in;
      end
    end
  end

endmodule

// File: tb/tb_impact_sram_access_ctrl.sv
// Bench for impact_sram_access_ctrl: four instances (default, 1/1/1, 4/15/3, 0/1/1) share one stimulus stream.
// A cycle-count reference model predicts every output; directed tables and sequences cover the corner cases.
// Outputs are sampled just after the falling edge; inputs change at the same point.
module tb_impact_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] bl_in;

  logic [3:0]  o_ready, o_rsp, o_wl, o_pre, o_wr, o_busy;
  logic [31:0] o_rdata [4];
  logic [4:0]  o_sel   [4];
  logic [31:0] o_bl    [4];
  logic [31:0] o_blb   [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int PP = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 0;
    localparam int AA = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 15 : 1;
    localparam int RR = (g == 0) ? 1 : (g == 1) ? 1 : (g == 2) ? 3 : 1;
    impact_sram_access_ctrl #(.PRE_CYCLES(PP), .ACC_CYCLES(AA), .REC_CYCLES(RR)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(o_ready[g]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(o_rsp[g]), .rsp_rdata(o_rdata[g]), .bl_in(bl_in),
      .wl_sel(o_sel[g]), .wl_en(o_wl[g]), .pre_en(o_pre[g]), .wr_en(o_wr[g]),
      .bl_drv(o_bl[g]), .blb_drv(o_blb[g]), .busy(o_busy[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: t = cycles since acceptance (-1 when idle); phases follow from P, A, R arithmetic.
  int          ep[4], ea[4], er[4];
  int          t[4];
  logic        mwe[4];
  logic [31:0] mwd[4];
  logic [4:0]  msel[4];
  logic [31:0] mrd[4];

  function automatic bit m_acc(input int i);
    return t[i] >= ep[i] + 1 && t[i] <= ep[i] + ea[i];
  endfunction

  task automatic model_next();
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        t[i] = -1; msel[i] = '0; mrd[i] = '0;
      end else if (t[i] < 0) begin
        if (req_valid) begin
          t[i] = 1; mwe[i] = req_we; mwd[i] = req_wdata; msel[i] = req_addr;
        end
      end else begin
        if (t[i] == ep[i] + ea[i] && !mwe[i]) mrd[i] = bl_in;
        if (t[i] == ep[i] + ea[i] + er[i]) t[i] = -1;
        else t[i] = t[i] + 1;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      logic acc, wr;
      acc = m_acc(i);
      wr  = acc && mwe[i];
      chk1($sformatf("i%0d_ready", i), o_ready[i], t[i] < 0 && !rst);
      chk1($sformatf("i%0d_busy", i), o_busy[i], t[i] >= 0);
      chk1($sformatf("i%0d_pre_en", i), o_pre[i], !acc);
      chk1($sformatf("i%0d_wl_en", i), o_wl[i], acc);
      chk1($sformatf("i%0d_wr_en", i), o_wr[i], wr);
      chk1($sformatf("i%0d_rsp_valid", i), o_rsp[i], t[i] == ep[i] + ea[i] + 1);
      chk($sformatf("i%0d_bl_drv", i), o_bl[i], wr ? mwd[i] : 32'h0);
      chk($sformatf("i%0d_blb_drv", i), o_blb[i], wr ? ~mwd[i] : 32'h0);
      chk($sformatf("i%0d_wl_sel", i), 32'(o_sel[i]), 32'(msel[i]));
      chk($sformatf("i%0d_rsp_rdata", i), o_rdata[i], mrd[i]);
      chk1($sformatf("i%0d_pre_wl_overlap", i), o_pre[i] & o_wl[i], 1'b0);
      chk1($sformatf("i%0d_wr_without_wl", i), o_wr[i] & ~o_wl[i], 1'b0);
    end
    chk1("p0_vs_p1_equiv",
         {o_ready[3], o_rsp[3], o_wl[3], o_pre[3], o_wr[3], o_busy[3]} ==
         {o_ready[1], o_rsp[1], o_wl[1], o_pre[1], o_wr[1], o_busy[1]} &&
         o_rdata[3] == o_rdata[1] && o_sel[3] == o_sel[1] && o_bl[3] == o_bl[1], 1'b1);
  endtask

  // Event log for the back-to-back phase.
  bit log_en = 0;
  int na[4], nr[4];
  int acc_c[4][4], rsp_c[4][4];

  task automatic log_events();
    if (!log_en) return;
    for (int i = 0; i < 4; i++) begin
      if (o_ready[i] && req_valid && na[i] < 4) begin acc_c[i][na[i]] = cyc; na[i]++; end
      if (o_rsp[i] && nr[i] < 4) begin rsp_c[i][nr[i]] = cyc; nr[i]++; end
    end
  endtask

  task automatic tick();
    #1;
    log_events();
    model_next();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (chk_en) check_model();
  endtask

  typedef struct {
    logic v; logic we; logic [4:0] addr; logic [31:0] wd; logic [31:0] bl;
    logic e_rdy; logic [4:0] e_sel; logic e_wl; logic e_wr; logic e_pre;
    logic [31:0] e_bl; logic [31:0] e_blb; logic e_rsp; logic [31:0] e_rd;
  } vec_t;
  vec_t tv[16];

  task automatic set_row(input int k, input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] wd, input logic [31:0] bl, input logic rdy,
                         input logic [4:0] sel, input logic wl, input logic wr, input logic pre,
                         input logic [31:0] ebl, input logic [31:0] eblb, input logic rsp,
                         input logic [31:0] rd);
    tv[k] = '{v, we, a, wd, bl, rdy, sel, wl, wr, pre, ebl, eblb, rsp, rd};
  endtask

  localparam logic [31:0] W  = 32'hA5A50F0F;
  localparam logic [31:0] WB = 32'h5A5AF0F0;
  localparam logic [31:0] D  = 32'h12345678;
  localparam int EXP_PER[4] = '{7, 4, 23, 4};
  localparam int EXP_LAT[4] = '{6, 3, 20, 3};

  initial begin
    // Write addr 5 (rows 0..7), then read addr 31 with bl_in driven only during ACC (rows 7..15).
    set_row(0,  1, 1, 5,  W, 0, 1, 0,  0, 0, 1, 0, 0,  0, 0);
    set_row(1,  0, 0, 0,  0, 0, 0, 5,  0, 0, 1, 0, 0,  0, 0);
    set_row(2,  0, 0, 0,  0, 0, 0, 5,  0, 0, 1, 0, 0,  0, 0);
    set_row(3,  0, 0, 0,  0, 0, 0, 5,  1, 1, 0, W, WB, 0, 0);
    set_row(4,  0, 0, 0,  0, 0, 0, 5,  1, 1, 0, W, WB, 0, 0);
    set_row(5,  0, 0, 0,  0, 0, 0, 5,  1, 1, 0, W, WB, 0, 0);
    set_row(6,  0, 0, 0,  0, 0, 0, 5,  0, 0, 1, 0, 0,  1, 0);
    set_row(7,  1, 0, 31, 0, 0, 1, 5,  0, 0, 1, 0, 0,  0, 0);
    set_row(8,  0, 0, 0,  0, 0, 0, 31, 0, 0, 1, 0, 0,  0, 0);
    set_row(9,  0, 0, 0,  0, 0, 0, 31, 0, 0, 1, 0, 0,  0, 0);
    set_row(10, 0, 0, 0,  0, D, 0, 31, 1, 0, 0, 0, 0,  0, 0);
    set_row(11, 0, 0, 0,  0, D, 0, 31, 1, 0, 0, 0, 0,  0, 0);
    set_row(12, 0, 0, 0,  0, D, 0, 31, 1, 0, 0, 0, 0,  0, 0);
    set_row(13, 0, 0, 0,  0, 0, 0, 31, 0, 0, 1, 0, 0,  1, D);
    set_row(14, 0, 0, 0,  0, 0, 1, 31, 0, 0, 1, 0, 0,  0, D);
    set_row(15, 0, 0, 0,  0, 0, 1, 31, 0, 0, 1, 0, 0,  0, D);

    begin
      int raw_p[4] = '{2, 1, 4, 0};
      int raw_a[4] = '{3, 1, 15, 1};
      int raw_r[4] = '{1, 1, 3, 1};
      for (int i = 0; i < 4; i++) begin
        ep[i] = (raw_p[i] < 1) ? 1 : raw_p[i];
        ea[i] = (raw_a[i] < 1) ? 1 : raw_a[i];
        er[i] = (raw_r[i] < 1) ? 1 : raw_r[i];
        t[i] = -1; mwe[i] = 0; mwd[i] = '0; msel[i] = '0; mrd[i] = '0;
        na[i] = 0; nr[i] = 0;
      end
    end

    // Reset
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; bl_in = '0;
    @(negedge clk);
    tick();
    chk_en = 1;
    check_model();
    chk1("reset_ready_low", o_ready[0], 1'b0);
    chk1("reset_pre_en", o_pre[0], 1'b1);
    chk("reset_rdata", o_rdata[0], 32'h0);
    tick(); tick();
    rst = 0;
    #1;
    chk1("ready_after_reset", o_ready[0], 1'b1);

    // Table-driven directed write then read on the default instance
    for (int k = 0; k < 16; k++) begin
      req_valid = tv[k].v; req_we = tv[k].we; req_addr = tv[k].addr;
      req_wdata = tv[k].wd; bl_in = tv[k].bl;
      #1;
      chk1($sformatf("tv%0d_ready", k), o_ready[0], tv[k].e_rdy);
      chk($sformatf("tv%0d_wl_sel", k), 32'(o_sel[0]), 32'(tv[k].e_sel));
      chk1($sformatf("tv%0d_wl_en", k), o_wl[0], tv[k].e_wl);
      chk1($sformatf("tv%0d_wr_en", k), o_wr[0], tv[k].e_wr);
      chk1($sformatf("tv%0d_pre_en", k), o_pre[0], tv[k].e_pre);
      chk($sformatf("tv%0d_bl_drv", k), o_bl[0], tv[k].e_bl);
      chk($sformatf("tv%0d_blb_drv", k), o_blb[0], tv[k].e_blb);
      chk1($sformatf("tv%0d_rsp_valid", k), o_rsp[0], tv[k].e_rsp);
      chk($sformatf("tv%0d_rsp_rdata", k), o_rdata[0], tv[k].e_rd);
      tick();
    end
    req_valid = 0;
    for (int k = 0; k < 30; k++) tick();

    // Reset held 3 cycles in the middle of a write's ACC phase
    req_valid = 1; req_we = 1; req_addr = 5'd7; req_wdata = $urandom;
    tick();
    req_valid = 0;
    tick(); tick(); tick();
    #1;
    chk1("midacc_wl_en_before_rst", o_wl[0], 1'b1);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("rst_wl_en", o_wl[0], 1'b0);
      chk1("rst_wr_en", o_wr[0], 1'b0);
      chk1("rst_pre_en", o_pre[0], 1'b1);
      chk1("rst_rsp_valid", o_rsp[0], 1'b0);
    end
    rst = 0;
    #1;
    chk1("ready_after_rst_falls", o_ready[0], 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("no_rsp_after_abort", o_rsp[0], 1'b0);
    end
    for (int k = 0; k < 20; k++) tick();

    // Back-to-back with req_valid held high
    log_en = 1;
    req_valid = 1;
    for (int k = 0; k < 110; k++) begin
      req_we = 1'($urandom); req_addr = 5'($urandom); req_wdata = $urandom; bl_in = $urandom;
      tick();
    end
    log_en = 0;
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("i%0d_b2b_accept_count", i), 32'(na[i]), 32'd4);
      chk($sformatf("i%0d_b2b_rsp_count", i), 32'(nr[i]), 32'd4);
      if (na[i] == 4 && nr[i] == 4) begin
        for (int j = 1; j < 4; j++)
          chk($sformatf("i%0d_b2b_period%0d", i, j), 32'(acc_c[i][j] - acc_c[i][j-1]), 32'(EXP_PER[i]));
        for (int j = 0; j < 4; j++)
          chk($sformatf("i%0d_b2b_latency%0d", i, j), 32'(rsp_c[i][j] - acc_c[i][j]), 32'(EXP_LAT[i]));
      end
    end
    for (int k = 0; k < 30; k++) tick();

    // Address sweep on the default instance
    for (int a = 0; a < 32; a++) begin
      bit got;
      got = 0;
      req_valid = 1; req_addr = 5'(a); req_we = 1'($urandom); req_wdata = $urandom;
      for (int k = 0; k < 30 && !got; k++) begin
        #1;
        got = o_ready[0];
        tick();
      end
      chk1($sformatf("sweep%0d_accepted", a), got, 1'b1);
      chk($sformatf("sweep%0d_wl_sel", a), 32'(o_sel[0]), 32'(a));
    end
    req_valid = 0;
    for (int k = 0; k < 30; k++) tick();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 5'($urandom);
      req_wdata = $urandom;
      bl_in     = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/impact_sram_access_ctrl.md
# impact_sram_access_ctrl

Access sequencer for one 32x32 IMPACT SRAM bank. It accepts single-word read/write requests over a valid/ready handshake and drives the bank's control signals in a fixed order: word-line select to the registered `BankWordDecoder`, bit-line precharge, word-line enable and write drivers. It then samples the sensed bit lines and returns read data. It sits between the chip-level request source (East pins / test logic) and the decoder + SRAM macro pair.

## Interface
Parameters:
- `PRE_CYCLES`, 2: minimum PRE-state duration in cycles; legal range 1..15; 0 is treated as 1.
- `ACC_CYCLES`, 3: word-line-active duration in cycles; legal range 1..15; 0 is treated as 1.
- `REC_CYCLES`, 1: recovery duration after word-line release; legal range 1..15; 0 is treated as 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  5  word line 0..31.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, for both reads and writes.
- `rsp_rdata`  out  32  last read data, held between reads.
- `bl_in`  in  32  sensed BL values from the bank.
- `wl_sel`  out  5  select to `BankWordDecoder.sel`.
- `wl_en`  out  1  word-line enable (gates decoder output).
- `pre_en`  out  1  bit-line precharge enable.
- `wr_en`  out  1  write-driver enable.
- `bl_drv`  out  32  BL drive value.
- `blb_drv`  out  32  BLb drive value.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, PRE, ACC, REC. A 4-bit down-counter times each state.
- IDLE:
  - `req_ready`=1 and `pre_en`=1.
  - On `req_valid && req_ready`: latch we/addr/wdata, load `wl_sel`=addr, enter PRE with count `PRE_CYCLES`.
  - `req_valid` without `req_ready` has no effect.
- PRE:
  - `pre_en`=1, `wl_en`=0, `wr_en`=0.
  - Leaves for ACC when the count expires.
  - `wl_sel` is already stable, so the registered decoder output has settled before ACC.
- ACC:
  - `pre_en`=0, `wl_en`=1.
  - If the request is a write: `wr_en`=1, `bl_drv`=wdata, `blb_drv`=~wdata.
  - On the final ACC cycle of a read: `rsp_rdata` <= `bl_in` at the closing edge.
  - Next state is REC.
- REC:
  - `wl_en`=0, `wr_en`=0, `pre_en`=1.
  - `rsp_valid`=1 in the first REC cycle only.
  - Returns to IDLE when the count expires.
- Drive outputs: `bl_drv` and `blb_drv` are 0 whenever `wr_en`=0.
- Invariants:
  - `pre_en` and `wl_en` are never both 1.
  - `wr_en` implies `wl_en`.
  - `wl_sel` changes only on request acceptance.
- A write does not modify `rsp_rdata`.
- Reset values: `req_ready`=0 while `rst` is high, then 1. All of the following are 0: `rsp_valid`, `rsp_rdata`, `wl_sel`, `wl_en`, `wr_en`, `bl_drv`, `blb_drv`, `busy`. `pre_en`=1. State = IDLE.
- Reset mid-operation: abort at the reset edge. `wl_en` and `wr_en` drop that edge, no `rsp_valid` is issued, and the aborted write has undefined cell content.

## Timing
- Define cycle 0 as the cycle ending at the acceptance edge. Let P, A, R be the effective parameter values.
- PRE: cycles 1..P.
- ACC (`wl_en`=1): cycles P+1..P+A.
- `rsp_valid`: cycle P+A+1, with `rsp_rdata` valid from the same cycle.
- REC: cycles P+A+1..P+A+R.
- `req_ready` returns in cycle P+A+R+1.
- Throughput: one access per P+A+R+1 cycles. With defaults, accept-to-`rsp_valid` = 6 cycles and request period = 7 cycles.
- `req_ready` is combinational from state only, never from `req_valid`.
- `rsp_valid` has no backpressure. The consumer must take it in the cycle it is asserted.

## Test plan
- Reset: hold `rst` 3 cycles mid-ACC of a write → next cycle `wl_en`=0, `wr_en`=0, `pre_en`=1, `rsp_valid` never pulses, `req_ready`=1 the cycle after `rst` falls.
- Write, defaults, addr 5, wdata 0xA5A50F0F:
  - `wl_sel`=5 from cycle 1.
  - `wl_en`=`wr_en`=1 in cycles 3..5.
  - `bl_drv`=0xA5A50F0F and `blb_drv`=0x5A5AF0F0 in those cycles only.
  - `rsp_valid` in cycle 6; `rsp_rdata` unchanged.
- Read, addr 31, `bl_in`=0x12345678 during ACC, 0 elsewhere → `rsp_rdata`=0x12345678 in cycle 6, held until the next read completes.
- Back-to-back: `req_valid` held high with 4 requests → acceptances exactly 7 cycles apart. `pre_en`/`wl_en` overlap never seen; `req_valid` during busy is ignored.
- Parameters P=1, A=1, R=1 and P=4, A=15, R=3 → `rsp_valid` at cycles 3 and 20, period 4 and 23 cycles. P=0 behaves identically to P=1.
- Address sweep 0..31 → `wl_sel` equals addr for the whole access and changes only on acceptance.
